// File: rtl/ram_arb_pkg.sv
// Shared types for the data-RAM arbiter: FSM states, port indices and the
// request record that carries a winner's access into the RAM registers.
package ram_arb_pkg;

    localparam int unsigned ARB_ADDR_W = 16;
    localparam int unsigned ARB_DATA_W = 16;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_WAIT
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic mem_req_t pack_req(input logic                  we,
                                          input logic [ARB_ADDR_W-1:0] addr,
                                          input logic [ARB_DATA_W-1:0] wdata);
        mem_req_t r;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/ram_arbiter_pick.sv
// Combinational winner select for the two RAM requesters.
// RAM_ARB_FIXED_PRIO_EN selects CPU-first priority with an aux starvation override.
module arb_pick
    import ram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    input  logic [1:0] excl_i,
    input  logic       starve_i,
    output logic       winner_o,
    output logic       valid_o
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic cand;
    logic unused_last_grant;

    assign unused_last_grant = last_grant_i;

    // An excluded top candidate yields no winner, so the just-acked CPU
    // re-arbitrates from IDLE instead of yielding to a non-starved aux.
    always_comb begin
        if (starve_i && req_i[PORT_AUX]) begin
            cand = PORT_AUX;
        end else if (req_i[PORT_CPU]) begin
            cand = PORT_CPU;
        end else begin
            cand = PORT_AUX;
        end
        winner_o = cand;
        valid_o  = (|req_i) && !excl_i[cand];
    end
`else
    logic [1:0] elig;
    logic       unused_starve;

    assign unused_starve = starve_i;

    always_comb begin
        elig    = req_i & ~excl_i;
        valid_o = |elig;
        if (&elig) begin
            winner_o = ~last_grant_i;
        end else begin
            winner_o = elig[PORT_AUX];
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Single-port data RAM arbiter between the CPU memory stage and an auxiliary master.
// Build option RAM_ARB_FIXED_PRIO_EN: CPU fixed priority with aux starvation limit MAX_WAIT.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ARB_ADDR_W,
    parameter int unsigned DATA_W   = ARB_DATA_W,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_ack,
    output logic [DATA_W-1:0] aux_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    arb_state_t        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_wren_q, ram_wren_d;

    logic [1:0] req_vec;
    logic [1:0] excl;
    logic       win;
    logic       win_vld;
    logic       starve;
    logic       load;
    mem_req_t   sel_req;

    assign req_vec = {aux_req, cpu_req};

    // The acked port still holds req during WAIT, so it is masked from the hand-off.
    assign excl = (state_q != ARB_WAIT) ? 2'b00 :
                  (grant_q == PORT_AUX) ? 2'b10 : 2'b01;

    assign sel_req = (win == PORT_AUX) ?
                     pack_req(aux_we, ARB_ADDR_W'(aux_addr), ARB_DATA_W'(aux_wdata)) :
                     pack_req(cpu_we, ARB_ADDR_W'(cpu_addr), ARB_DATA_W'(cpu_wdata));

    arb_pick u_pick (
        .req_i       (req_vec),
        .last_grant_i(last_grant_q),
        .excl_i      (excl),
        .starve_i    (starve),
        .winner_o    (win),
        .valid_o     (win_vld)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_wren_d   = ram_wren_q;
        load         = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                load = win_vld;
            end
            ARB_ACCESS: begin
                ram_wren_d = 1'b0;
                state_d    = ARB_WAIT;
            end
            ARB_WAIT: begin
                last_grant_d = grant_q;
                state_d      = ARB_IDLE;
                load         = win_vld;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        if (load) begin
            state_d     = ARB_ACCESS;
            grant_d     = win;
            ram_addr_d  = ADDR_W'(sel_req.addr);
            ram_wdata_d = DATA_W'(sel_req.wdata);
            ram_wren_d  = sel_req.we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= PORT_CPU;
            last_grant_q <= PORT_AUX;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_wren_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_wren_q   <= ram_wren_d;
        end
    end

`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam int unsigned       CNT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             aux_served;

    assign aux_served = ((state_q != ARB_IDLE) && (grant_q == PORT_AUX)) ||
                        (load && (win == PORT_AUX));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!aux_req || aux_served) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign starve = (wait_cnt_q == WAIT_LIMIT);
`else
    logic unused_max_wait;

    assign unused_max_wait = (MAX_WAIT == 0);
    assign starve          = 1'b0;
`endif

    assign cpu_ack   = (state_q == ARB_WAIT) && (grant_q == PORT_CPU);
    assign aux_ack   = (state_q == ARB_WAIT) && (grant_q == PORT_AUX);
    assign cpu_rdata = cpu_ack ? ram_q : '0;
    assign aux_rdata = aux_ack ? ram_q : '0;
    assign cpu_stall = cpu_req & ~cpu_ack;

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wren  = ram_wren_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: per-cycle vector table plus multi-cycle
// sequences for port alternation, reset during an access and fixed priority.
module tb_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, aux_req, aux_we;
    logic [15:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
    logic        cpu_ack, cpu_stall, aux_ack, ram_wren;
    logic [15:0] cpu_rdata, aux_rdata, ram_addr, ram_wdata, ram_q;

    logic        pl_we;
    logic [15:0] pl_addr, pl_data;
    logic [15:0] mem [0:65535];

    int tests = 0;
    int fails = 0;

    ram_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .aux_req  (aux_req),
        .aux_we   (aux_we),
        .aux_addr (aux_addr),
        .aux_wdata(aux_wdata),
        .aux_ack  (aux_ack),
        .aux_rdata(aux_rdata),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_wren (ram_wren),
        .ram_q    (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the clock after the address is sampled.
    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_q <= mem[ram_addr];
    end

    typedef struct {
        logic        rst;
        logic        creq;
        logic        cwe;
        logic [15:0] caddr;
        logic [15:0] cwd;
        logic        areq;
        logic        awe;
        logic [15:0] aaddr;
        logic [15:0] awd;
        logic        e_cack;
        logic        e_stall;
        logic        e_aack;
        logic        e_wren;
        logic [15:0] e_crd;
        logic [15:0] e_ard;
        logic [15:0] e_raddr;
        logic [15:0] e_rwd;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        aux_req = 1'b0; aux_we = 1'b0; aux_addr = 16'h0; aux_wdata = 16'h0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        pl_we = 1'b0; pl_addr = 16'h0; pl_data = 16'h0;
        idle_inputs();
        tick();
        preload(16'h0010, 16'hBEEF);
        preload(16'h0020, 16'h0000);
        preload(16'h0030, 16'hCAFE);
        preload(16'h0040, 16'h5A5A);
        preload(16'h0050, 16'h0000);

        //          rst creq cwe caddr    cwd      areq awe aaddr    awd       cack stl aack wren crd      ard      raddr    rwd
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 16'h0000};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 16'h0010, 16'h0000};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 16'h0000};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0020, 16'h1234};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0020, 16'h1234};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0020, 16'h1234};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0020, 16'h0000};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0020, 16'h0000};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0020, 16'h0000};

        for (int i = 0; i < NV; i++) begin
            reset     = vecs[i].rst;
            cpu_req   = vecs[i].creq;  cpu_we = vecs[i].cwe;
            cpu_addr  = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
            aux_req   = vecs[i].areq;  aux_we = vecs[i].awe;
            aux_addr  = vecs[i].aaddr; aux_wdata = vecs[i].awd;
            #1;
            chk($sformatf("v%0d.cpu_ack", i),   32'(cpu_ack),   32'(vecs[i].e_cack));
            chk($sformatf("v%0d.cpu_stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d.aux_ack", i),   32'(aux_ack),   32'(vecs[i].e_aack));
            chk($sformatf("v%0d.ram_wren", i),  32'(ram_wren),  32'(vecs[i].e_wren));
            chk($sformatf("v%0d.cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].e_crd));
            chk($sformatf("v%0d.aux_rdata", i), 32'(aux_rdata), 32'(vecs[i].e_ard));
            chk($sformatf("v%0d.ram_addr", i),  32'(ram_addr),  32'(vecs[i].e_raddr));
            chk($sformatf("v%0d.ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].e_rwd));
            tick();
        end

`ifndef RAM_ARB_FIXED_PRIO_EN
        // Both ports requesting from reset: CPU, aux, CPU, aux with acks 2 cycles apart.
        reset = 1'b0; #1; reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0040;
        for (int c = 1; c <= 10; c++) begin
            #1;
            chk($sformatf("alt.c%0d.cpu_ack", c), 32'(cpu_ack), 32'((c == 3) || (c == 7)));
            chk($sformatf("alt.c%0d.aux_ack", c), 32'(aux_ack), 32'((c == 5) || (c == 9)));
            if (c == 3 || c == 7) chk($sformatf("alt.c%0d.cpu_rdata", c), 32'(cpu_rdata), 32'h0000CAFE);
            if (c == 5 || c == 9) chk($sformatf("alt.c%0d.aux_rdata", c), 32'(aux_rdata), 32'h00005A5A);
            tick();
        end
        idle_inputs();
        repeat (4) tick();
`endif

        // Reset while an aux write sits in ACCESS: write abandoned, no ack, then reissued.
        idle_inputs();
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 16'h0050; aux_wdata = 16'h7777;
        tick();
        chk("rstmid.wren_in_access", 32'(ram_wren), 32'd1);
        reset = 1'b0;
        #1;
        chk("rstmid.wren_async_drop", 32'(ram_wren), 32'd0);
        chk("rstmid.aux_ack", 32'(aux_ack), 32'd0);
        chk("rstmid.ram_addr", 32'(ram_addr), 32'd0);
        tick();
        chk("rstmid.aux_ack_held", 32'(aux_ack), 32'd0);
        chk("rstmid.mem_untouched", 32'(mem[16'h0050]), 32'h0);
        reset = 1'b1;
        begin
            int  n;
            bit  got;
            n   = 0;
            got = 1'b0;
            for (int k = 1; k <= 10 && !got; k++) begin
                #1;
                if (aux_ack) begin
                    got = 1'b1;
                    n   = k;
                end else begin
                    tick();
                end
            end
            chk("rstmid.reissue_ack_cycle", 32'(n), 32'd3);
        end
        tick();
        idle_inputs();
        tick();
        chk("rstmid.mem_written", 32'(mem[16'h0050]), 32'h00007777);

`ifdef RAM_ARB_FIXED_PRIO_EN
        // CPU holds req; aux starves for MAX_WAIT cycles, gets one slot, CPU resumes.
        reset = 1'b0; #1; reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0040;
        begin
            int cpu_before;
            int aux_cyc;
            int cpu_after;
            cpu_before = 0;
            aux_cyc    = 0;
            cpu_after  = 0;
            for (int c = 1; c <= 20; c++) begin
                #1;
                if (aux_ack && aux_cyc == 0) aux_cyc = c;
                if (cpu_ack && aux_cyc == 0) cpu_before++;
                if (cpu_ack && aux_cyc != 0 && cpu_after == 0) cpu_after = c;
                tick();
            end
            chk("fixed.cpu_acks_before_aux", 32'(cpu_before), 32'd3);
            chk("fixed.aux_ack_cycle", 32'(aux_cyc), 32'd11);
            chk("fixed.cpu_resume_cycle", 32'(cpu_after), 32'd13);
        end
        idle_inputs();
        repeat (4) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
